tft_frame_feeder: RTL and testbench
===================================

# tft_frame_feeder

Upstream word source for the TFT SPI serializer. Buffers RGB565 pixels written by the video/CPU side in a small FIFO, prefixes every frame with the window-setup command sequence (CASET/RASET/RAMWR), and presents one 16-bit word plus its RS level at a time. The serializer consumes each word with a one-cycle request strobe. Tracks pixel position, flags underruns and pulses at end of frame.

## Interface
- WIDTH, 128: panel columns.
- HEIGHT, 160: panel rows.
- FIFO_DEPTH, 16: pixel FIFO entries; must be a power of two.
- PTR_BITS, 4: log2(FIFO_DEPTH).
- PIX_BITS, 15: pixel counter width; must satisfy 2^PIX_BITS ≥ WIDTH*HEIGHT.

Ports:
- MasterCLK  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  level; starts and continues frame streaming.
- wr_en  in  1  pixel write strobe.
- wr_data  in  16  RGB565 pixel.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- level  out  PTR_BITS+1  FIFO occupancy, 0..FIFO_DEPTH.
- word_req  in  1  one-cycle pulse from the serializer: the presented word is consumed.
- out_data  out  16  word presented to the serializer.
- out_rs  out  1  0 = command, 1 = parameter/pixel.
- out_valid  out  1  out_data/out_rs hold a word.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is consumed.
- underrun  out  1  sticky; a pixel was presented while the FIFO was empty.

## Operation
- Reset values: out_data=0, out_rs=0, out_valid=0, full=0, level=0, frame_done=0, underrun=0. FIFO pointers=0. Pixel counter=0. Command index=0. State=IDLE.
- FIFO: synchronous write when wr_en && !full. A write while full is dropped and leaves the contents unchanged. Simultaneous write and pop with a non-full FIFO keeps level unchanged. Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: out_valid=0. When enable=1, load command word 0 and go to CMD.
  - CMD: 7-word sequence, given as (data, rs): (0x002A,0), (0x0000,1), (WIDTH-1,1), (0x002B,0), (0x0000,1), (HEIGHT-1,1), (0x002C,0). Each word_req advances the index and loads the next word. A word_req on index 6 goes to PIXEL and loads the first pixel.
  - PIXEL: when loading a pixel, pop the FIFO head if level>0 and set out_rs=1. If the FIFO is empty, present 0x0000 with out_rs=1 and set underrun. Each word_req increments the pixel counter and loads the next pixel.
  - End of frame: a word_req when the counter = WIDTH*HEIGHT-1 clears the counter and pulses frame_done. If enable=1, load CMD word 0 and go to CMD. Otherwise set out_valid=0 and go to IDLE.
- Deasserting enable mid-frame does not abort. The current frame completes, then the block idles.
- underrun clears only on reset or when a new CMD sequence starts from IDLE.
- word_req while out_valid=0 is ignored.

## Timing
- IDLE→CMD: out_valid=1 with word 0 on the first clock edge where enable=1.
- word_req seen at edge N: the next word is on out_data/out_rs after edge N, so word_req may repeat every cycle.
- The FIFO pop for a presented pixel happens in the same edge that loads out_data. level reflects it after that edge.
- A wr_en in the same cycle that an empty FIFO is popped does not bypass. That pixel underruns and the written word stays queued.
- frame_done is high for exactly the cycle after the final consuming word_req.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. Streaming restarts at CMD word 0 after release.

## Test plan
- Reset, then enable=1 with WIDTH=4, HEIGHT=2 and word_req every cycle -> out_data sequence 0x002A,0x0000,0x0003,0x002B,0x0000,0x0001,0x002C with rs 0,1,1,0,1,1,0.
- Prefill 8 pixels 0x1000..0x1007, run one frame -> the 8 pixels appear in order with rs=1, frame_done pulses once, underrun=0, CMD word 0 follows.
- FIFO empty in PIXEL -> out_data=0x0000 and underrun=1. underrun stays set through the next frame while enable stays high.
- 17 writes into FIFO_DEPTH=16 -> full=1 and level=16 after the 16th write. The 17th value never appears on out_data.
- Drop enable mid-frame -> remaining pixels still stream, frame_done pulses, then out_valid=0 in IDLE.
- Assert reset during PIXEL -> all outputs 0 immediately. After release with enable=1, the first word is 0x002A.

Source files
------------

// File: rtl/tft_frame_feeder_if.sv
// Signal bundle between the pixel source, tft_frame_feeder and the TFT SPI serializer.
// The feeder drives the status and presented-word side; the source/serializer side drives the rest.
interface tft_frame_feeder_if #(
  parameter int PTR_BITS = 4
) ();
  logic                enable;
  logic                wr_en;
  logic [15:0]         wr_data;
  logic                full;
  logic [PTR_BITS:0]   level;
  logic                word_req;
  logic [15:0]         out_data;
  logic                out_rs;
  logic                out_valid;
  logic                frame_done;
  logic                underrun;

  modport slave (
    input  enable, wr_en, wr_data, word_req,
    output full, level, out_data, out_rs, out_valid, frame_done, underrun
  );

  modport master (
    output enable, wr_en, wr_data, word_req,
    input  full, level, out_data, out_rs, out_valid, frame_done, underrun
  );
endinterface

// File: rtl/tft_frame_feeder.sv
// Pixel FIFO plus frame sequencer: emits CASET/RASET/RAMWR setup words, then WIDTH*HEIGHT
// pixels, one word per serializer request, with end-of-frame pulse and sticky underrun flag.
module tft_frame_feeder #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 160,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_BITS   = 4,
  parameter int PIX_BITS   = 15
) (
  input  logic              MasterCLK,
  input  logic              reset,
  tft_frame_feeder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, PIXEL} state_e;

  localparam int                  LVL_W    = PTR_BITS + 1;
  localparam logic [PIX_BITS-1:0] LAST_PIX = PIX_BITS'(WIDTH * HEIGHT - 1);
  localparam logic [PIX_BITS-1:0] PIX_ONE  = PIX_BITS'(1);
  localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]    LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
  localparam logic [2:0]          LAST_CMD = 3'd6;

  state_e              state_q, state_d;
  logic [2:0]          cmd_idx_q, cmd_idx_d;
  logic [PIX_BITS-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                out_rs_q, out_rs_d;
  logic                out_valid_q, out_valid_d;
  logic                underrun_q, underrun_d;
  logic                frame_done_q, frame_done_d;

  logic [15:0]         mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;

  logic full, push, pop, consume, load_pixel;

  // Window-setup sequence as {rs, data}.
  function automatic logic [16:0] cmd_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_rom = {1'b0, 16'h002A};
      3'd1:    cmd_rom = {1'b1, 16'h0000};
      3'd2:    cmd_rom = {1'b1, 16'(WIDTH - 1)};
      3'd3:    cmd_rom = {1'b0, 16'h002B};
      3'd4:    cmd_rom = {1'b1, 16'h0000};
      3'd5:    cmd_rom = {1'b1, 16'(HEIGHT - 1)};
      default: cmd_rom = {1'b0, 16'h002C};
    endcase
  endfunction

  assign full    = (level_q == LVL_FULL);
  assign push    = bus.wr_en && !full;
  assign consume = bus.word_req && out_valid_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cmd_idx_d    = cmd_idx_q;
    pix_cnt_d    = pix_cnt_q;
    out_data_d   = out_data_q;
    out_rs_d     = out_rs_q;
    out_valid_d  = out_valid_q;
    underrun_d   = underrun_q;
    frame_done_d = 1'b0;
    load_pixel   = 1'b0;
    pop          = 1'b0;

    unique case (state_q)
      IDLE: if (bus.enable) begin
        state_d                = CMD;
        cmd_idx_d              = 3'd0;
        {out_rs_d, out_data_d} = cmd_rom(3'd0);
        out_valid_d            = 1'b1;
        underrun_d             = 1'b0;
      end
      CMD: if (consume) begin
        if (cmd_idx_q == LAST_CMD) begin
          state_d    = PIXEL;
          load_pixel = 1'b1;
        end else begin
          cmd_idx_d              = cmd_idx_q + 3'd1;
          {out_rs_d, out_data_d} = cmd_rom(cmd_idx_q + 3'd1);
        end
      end
      PIXEL: if (consume) begin
        if (pix_cnt_q == LAST_PIX) begin
          pix_cnt_d    = '0;
          frame_done_d = 1'b1;
          if (bus.enable) begin
            state_d                = CMD;
            cmd_idx_d              = 3'd0;
            {out_rs_d, out_data_d} = cmd_rom(3'd0);
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end else begin
          pix_cnt_d  = pix_cnt_q + PIX_ONE;
          load_pixel = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An empty FIFO still yields a pixel slot; the write of this same cycle is not bypassed.
    if (load_pixel) begin
      out_rs_d = 1'b1;
      if (level_q != '0) begin
        pop        = 1'b1;
        out_data_d = mem_q[rd_ptr_q];
      end else begin
        out_data_d = 16'h0000;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MasterCLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_idx_q    <= '0;
      pix_cnt_q    <= '0;
      out_data_q   <= '0;
      out_rs_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_idx_q    <= cmd_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      out_data_q   <= out_data_d;
      out_rs_q     <= out_rs_d;
      out_valid_q  <= out_valid_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; level/pointers alone decide what is valid.
  always_ff @(posedge MasterCLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full       = full;
  assign bus.level      = level_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_rs     = out_rs_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_tft_frame_feeder.sv
// Self-checking bench for tft_frame_feeder on a 4x2 panel; the reference model treats a frame
// as a flat list of 7 setup words followed by WIDTH*HEIGHT pixel slots fed from a queue.
module tb_tft_frame_feeder;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DEPTH = 16;
  localparam int PB    = 4;
  localparam int FRAME = 7 + W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tft_frame_feeder_if #(.PTR_BITS(PB)) bus ();

  tft_frame_feeder #(
    .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(DEPTH), .PTR_BITS(PB), .PIX_BITS(15)
  ) dut (
    .MasterCLK(clk),
    .reset    (rst),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic        m_valid;
  int          m_pos;
  logic [15:0] m_data;
  logic        m_rs;
  logic        m_under;
  logic        m_done;

  function automatic logic [16:0] frame_cmd(input int idx);
    case (idx)
      0:       return {1'b0, 16'h002A};
      1:       return {1'b1, 16'h0000};
      2:       return {1'b1, 16'(W - 1)};
      3:       return {1'b0, 16'h002B};
      4:       return {1'b1, 16'h0000};
      5:       return {1'b1, 16'(H - 1)};
      default: return {1'b0, 16'h002C};
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0; m_pos = 0; m_data = '0; m_rs = 1'b0; m_under = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_load(input int pos);
    if (pos < 7) begin
      {m_rs, m_data} = frame_cmd(pos);
    end else begin
      m_rs = 1'b1;
      if (mq.size() > 0) m_data = mq.pop_front();
      else begin
        m_data  = 16'h0000;
        m_under = 1'b1;
      end
    end
  endtask

  task automatic model_edge(input logic en, input logic we, input logic [15:0] wd, input logic req);
    logic push_ok;
    push_ok = we && (mq.size() < DEPTH);
    m_done  = 1'b0;
    if (!m_valid) begin
      if (en) begin
        m_valid = 1'b1; m_under = 1'b0; m_pos = 0;
        model_load(0);
      end
    end else if (req) begin
      if (m_pos == FRAME - 1) begin
        m_done = 1'b1;
        m_pos  = 0;
        if (en) model_load(0);
        else    m_valid = 1'b0;
      end else begin
        m_pos++;
        model_load(m_pos);
      end
    end
    if (push_ok) mq.push_back(wd);
  endtask

  function automatic logic [8:0] model_status();
    return {m_valid, m_done, m_under, (mq.size() == DEPTH), 5'(mq.size())};
  endfunction

  function automatic logic [8:0] dut_status();
    return {bus.out_valid, bus.frame_done, bus.underrun, bus.full, bus.level};
  endfunction

  // Inputs change at the falling edge; the model advances at the rising edge.
  task automatic step(input logic en, input logic we, input logic [15:0] wd, input logic req);
    bus.enable = en; bus.wr_en = we; bus.wr_data = wd; bus.word_req = req;
    @(posedge clk);
    model_edge(en, we, wd, req);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.word_req = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.word_req = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    vectors++; if (bus.out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data); end
    vectors++; if (bus.out_rs !== 1'b0) begin miscompares++; $display("FAIL reset_out_rs: got %b expected 0", bus.out_rs); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    vectors++; if (bus.level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    vectors++; if (bus.underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %b expected 0", bus.underrun); end
    rst = 1'b0;
  endtask

  task automatic test_cmd_sequence();
    logic [15:0] exp_d [7];
    logic [6:0]  exp_rs;
    exp_d  = '{16'h002A, 16'h0000, 16'h0003, 16'h002B, 16'h0000, 16'h0001, 16'h002C};
    exp_rs = 7'b0110110;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      vectors++;
      if ({bus.out_valid, bus.out_rs, bus.out_data} !== {1'b1, exp_rs[i], exp_d[i]}) begin
        miscompares++;
        $display("FAIL cmd_word%0d: got v=%b rs=%b data=%h expected v=1 rs=%b data=%h",
                 i, bus.out_valid, bus.out_rs, bus.out_data, exp_rs[i], exp_d[i]);
      end
      vectors++;
      if (dut_status() !== model_status()) begin
        miscompares++; $display("FAIL cmd_status: got %h expected %h", dut_status(), model_status());
      end
    end
  endtask

  task automatic test_prefill_frame();
    int done_cnt;
    done_cnt = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b0);
      vectors++;
      if (bus.level !== 5'(i + 1)) begin miscompares++; $display("FAIL prefill_level: got %0d expected %0d", bus.level, i + 1); end
    end
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      done_cnt += int'(bus.frame_done);
      if (k >= 8 && k <= 15) begin
        vectors++;
        if ({bus.out_rs, bus.out_data} !== {1'b1, 16'h1000 + 16'(k - 8)}) begin
          miscompares++;
          $display("FAIL prefill_pixel%0d: got rs=%b data=%h expected rs=1 data=%h",
                   k - 8, bus.out_rs, bus.out_data, 16'h1000 + 16'(k - 8));
        end
      end
      vectors++;
      if (dut_status() !== model_status()) begin
        miscompares++; $display("FAIL prefill_status: got %h expected %h", dut_status(), model_status());
      end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL prefill_done_count: got %0d expected 1", done_cnt); end
    vectors++; if (bus.underrun !== 1'b0) begin miscompares++; $display("FAIL prefill_underrun: got %b expected 0", bus.underrun); end
    vectors++;
    if ({bus.out_valid, bus.out_rs, bus.out_data} !== {1'b1, 1'b0, 16'h002A}) begin
      miscompares++; $display("FAIL prefill_next_cmd0: got v=%b rs=%b data=%h expected v=1 rs=0 data=002a",
                              bus.out_valid, bus.out_rs, bus.out_data);
    end
  endtask

  // Continues from the prefill frame: setup word 0 presented, FIFO empty.
  task automatic test_underrun();
    for (int k = 1; k <= 6; k++) step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'hBEEF, 1'b1);
    vectors++;
    if ({bus.out_data, bus.underrun, bus.level} !== {16'h0000, 1'b1, 5'd1}) begin
      miscompares++; $display("FAIL underrun_first: got data=%h ur=%b lvl=%0d expected data=0000 ur=1 lvl=1",
                              bus.out_data, bus.underrun, bus.level);
    end
    step(1'b1, 1'b0, 16'h0, 1'b1);
    vectors++;
    if (bus.out_data !== 16'hBEEF) begin miscompares++; $display("FAIL underrun_no_bypass: got %h expected beef", bus.out_data); end
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 1'b1, 16'hC000 + 16'(k), 1'b1);
      vectors++;
      if (dut_status() !== model_status()) begin
        miscompares++; $display("FAIL underrun_status: got %h expected %h", dut_status(), model_status());
      end
      if (m_valid) begin
        vectors++;
        if ({bus.out_rs, bus.out_data} !== {m_rs, m_data}) begin
          miscompares++; $display("FAIL underrun_word: got %b/%h expected %b/%h", bus.out_rs, bus.out_data, m_rs, m_data);
        end
      end
    end
    vectors++; if (bus.underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_sticky: got %b expected 1", bus.underrun); end
  endtask

  task automatic test_overflow();
    logic seen17;
    seen17 = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0);
      if (i >= 15) begin
        vectors++;
        if ({bus.full, bus.level} !== {1'b1, 5'd16}) begin
          miscompares++; $display("FAIL overflow_full%0d: got full=%b lvl=%0d expected full=1 lvl=16", i + 1, bus.full, bus.level);
        end
      end
    end
    for (int k = 0; k < 2 * FRAME + 1; k++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      if (bus.out_valid === 1'b1 && bus.out_data === 16'h2010) seen17 = 1'b1;
      vectors++;
      if (dut_status() !== model_status()) begin
        miscompares++; $display("FAIL overflow_status: got %h expected %h", dut_status(), model_status());
      end
      if (m_valid) begin
        vectors++;
        if ({bus.out_rs, bus.out_data} !== {m_rs, m_data}) begin
          miscompares++; $display("FAIL overflow_word: got %b/%h expected %b/%h", bus.out_rs, bus.out_data, m_rs, m_data);
        end
      end
    end
    vectors++; if (seen17 !== 1'b0) begin miscompares++; $display("FAIL overflow_dropped: got seen=1 expected seen=0"); end
  endtask

  task automatic test_enable_drop();
    int   guard;
    logic seen_done;
    guard = 0; seen_done = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h4000 + 16'(i), 1'b0);
    while (!(m_valid && m_pos >= 10) && guard < 200) begin
      step(1'b1, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      guard++;
    end
    while (!seen_done && guard < 400) begin
      step(1'b0, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      if (bus.frame_done === 1'b1) seen_done = 1'b1;
      vectors++;
      if (dut_status() !== model_status()) begin
        miscompares++; $display("FAIL drop_status: got %h expected %h", dut_status(), model_status());
      end
      if (m_valid) begin
        vectors++;
        if ({bus.out_rs, bus.out_data} !== {m_rs, m_data}) begin
          miscompares++; $display("FAIL drop_word: got %b/%h expected %b/%h", bus.out_rs, bus.out_data, m_rs, m_data);
        end
      end
      guard++;
    end
    vectors++; if (!seen_done) begin miscompares++; $display("FAIL drop_frame_done_timeout: got none expected pulse within 400 cycles"); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_idle_valid: got %b expected 0", bus.out_valid); end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h3000 + 16'(i), 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 16'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.out_data, bus.out_rs, bus.out_valid, bus.full, bus.level, bus.frame_done, bus.underrun} !== 25'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: got data=%h rs=%b v=%b full=%b lvl=%0d done=%b ur=%b expected all 0",
               bus.out_data, bus.out_rs, bus.out_valid, bus.full, bus.level, bus.frame_done, bus.underrun);
    end
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.word_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.out_rs, bus.out_data} !== {1'b1, 1'b0, 16'h002A}) begin
      miscompares++; $display("FAIL midframe_restart: got v=%b rs=%b data=%h expected v=1 rs=0 data=002a",
                              bus.out_valid, bus.out_rs, bus.out_data);
    end
  endtask

  task automatic test_random();
    logic en;
    int   wr_pct;
    en = 1'b1; wr_pct = 50;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 63) == 0) en = ~en;
      if (k % 200 == 0) wr_pct = ($urandom_range(0, 1) == 1) ? 95 : 25;
      step(en, 1'($urandom_range(0, 99) < wr_pct), 16'($urandom), 1'($urandom_range(0, 99) < 70));
      vectors++;
      if (dut_status() !== model_status()) begin
        miscompares++; $display("FAIL random_status@%0d: got %h expected %h", k, dut_status(), model_status());
      end
      if (m_valid) begin
        vectors++;
        if ({bus.out_rs, bus.out_data} !== {m_rs, m_data}) begin
          miscompares++; $display("FAIL random_word@%0d: got %b/%h expected %b/%h", k, bus.out_rs, bus.out_data, m_rs, m_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cmd_sequence();
    test_prefill_frame();
    test_underrun();
    test_overflow();
    test_enable_drop();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
